vector_alu_pipe: RTL and testbench
==================================

# vector_alu_pipe

Parametrised, handshaked successor to the combinational vector ALU. It executes per-lane integer ops and the AES round primitives on an `LANES*LANE_W`-bit vector. SubBytes runs iteratively over a configurable number of S-box lookups per cycle, and the result is held stable until the consumer accepts it. The block sits in the execute stage between the vector register file read and the vector writeback/memory path. It stalls the front end through `in_ready`.

## Interface
Parameters:
- `LANES`, 16, number of lanes.
- `LANE_W`, 8, lane width in bits.
- `SBOX_PER_CYC`, 4, S-box lookups per cycle; must divide `LANES*LANE_W/8`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept a request.
- `op` in 5: opcode.
- `src_a` in `LANES*LANE_W`: operand A.
- `src_b` in `LANES*LANE_W`: operand B.
- `out_valid` out 1: `result` is valid.
- `out_ready` in 1: consumer accepts `result`.
- `result` out `LANES*LANE_W`: registered result.
- `busy` out 1: an operation is in flight, i.e. state not IDLE.

## Operation
- FSM states and transitions:
  - IDLE: on accept, go to EXEC for single-cycle ops, or to SBOX for SUBBYTES.
  - EXEC: after 1 cycle, go to DONE.
  - SBOX: run for `NSB = LANES*LANE_W/8/SBOX_PER_CYC` cycles, then go to DONE.
  - DONE: on `out_ready`, go to IDLE. If a new request is accepted in that same cycle, go directly to EXEC or SBOX.
- Accept condition: `in_valid && in_ready`. On accept, `op`, `src_a` and `src_b` are captured into internal registers; inputs may change afterwards.
- `in_ready` is high in IDLE, and in DONE while `out_ready` is high. It is 0 while `rst` is high.
- Per-lane ops: lane i uses bits `[i*LANE_W +: LANE_W]`. All arithmetic is modulo 2^LANE_W, with no carry between lanes.
  - 00001 ADD.
  - 00010 SUB.
  - 00011 AND.
  - 00100 OR.
  - 00101 XOR.
  - 00110 SHL by `b[2:0]`.
  - 00111 SHR (logical) by `b[2:0]`.
- AES ops are legal only when `LANES*LANE_W==128` and `LANE_W==8`. Byte k = bits `[8k+7:8k]`; the state is column-major, so row = k%4 and column = k/4.
  - 10011 ADDROUNDKEY: A^B over the full 128 bits.
  - 10100 SHIFTROWS: row r is rotated left by r columns.
  - 10101 MIXCOLUMNS: standard GF(2^8) matrix 02 03 01 01, using xtime with polynomial 0x1B.
  - 10110 ROTWORD: low word {b3,b2,b1,b0} becomes {b0,b3,b2,b1}; upper bits are 0.
  - 10111 RCON: result[7:0] = rcon(`b[3:0]`) for index 1..10 (01,02,04,08,10,20,40,80,1B,36); otherwise 00. Upper bits are 0.
  - 11000 SUBBYTES: bytes `[c*SBOX_PER_CYC +: SBOX_PER_CYC]` are substituted in cycle c = 0..NSB-1, written into `result` incrementally.
- 00000 NOP, unknown opcodes, and AES opcodes under an illegal geometry all complete through EXEC with `result` = 0.

## Timing
- Reset values: `out_valid` 0, `result` 0, `busy` 0, state IDLE, SBOX counter 0.
- Single-cycle op: accepted at edge k, `out_valid` rises after edge k+1. Latency is 1.
- SUBBYTES: `out_valid` rises NSB edges after the accept edge. For the default parameters NSB = 4.
- Back-pressure: in DONE with `out_ready` low, `result` and `out_valid` hold indefinitely and `in_ready` stays 0.
- Back-to-back: when `out_ready` and `in_valid` are both high in DONE, the handoff and the new accept happen on the same edge, with no bubble.
- Mid-operation reset: `rst` asserted in any state clears all registers immediately; the partial SUBBYTES result is discarded.
- `result` changes only on an EXEC/SBOX write or on reset. In SBOX, intermediate bytes are not observable because `out_valid` is 0.

## Structure
- `vector_alu_pkg` contains:
  - the `op_e` opcode enum;
  - the `state_e` FSM enum;
  - the RCON table constant;
  - `xtime`, `mix_col` and `shift_rows` functions.
- Sub-module `aes_sbox`: a combinational 8-bit S-box lookup, instantiated `SBOX_PER_CYC` times and fed by a byte-select mux driven by the SBOX counter.
- The top level contains the FSM, operand/result registers, lane generate loop, and result mux.

## Test plan
- XOR with A=0x0F repeated, B=0xFF repeated: one cycle after accept, `result` = 0xF0 repeated and `out_valid` = 1.
- ADD with lane A=0xFF, B=0x01: the lane gives 0x00 with no carry into the neighbour. SUB 0x00-0x01 gives 0xFF.
- SUBBYTES with byte k = k (0x00..0x0F), `SBOX_PER_CYC`=4: `out_valid` exactly 4 cycles after accept. byte0 = 0x63, byte1 = 0x7C, byte15 = 0x76.
- MIXCOLUMNS with column 0 = db,13,53,45: column 0 becomes 8e,4d,a1,bc. RCON with `b[3:0]`=9 gives 0x1B; with index 0 gives 0.
- Back-pressure: hold `out_ready` low for 3 cycles, then pulse it with `in_valid` high. `result` is stable for 3 cycles, `in_ready` is 0, and the next op is accepted on the handoff edge with no bubble.
- Reset in cycle 2 of SUBBYTES: `out_valid` is 0 and `result` is 0 immediately, and `in_ready` = 1 after `rst` deasserts. Opcode 01111 completes with `result` = 0.

Source files
------------

// File: rtl/vector_alu_pkg.sv
// Shared types and AES helpers for the vector ALU pipeline.
package vector_alu_pkg;

    typedef enum logic [4:0] {
        OP_NOP      = 5'b00000,
        OP_ADD      = 5'b00001,
        OP_SUB      = 5'b00010,
        OP_AND      = 5'b00011,
        OP_OR       = 5'b00100,
        OP_XOR      = 5'b00101,
        OP_SHL      = 5'b00110,
        OP_SHR      = 5'b00111,
        OP_ADDRK    = 5'b10011,
        OP_SHROWS   = 5'b10100,
        OP_MIXCOL   = 5'b10101,
        OP_ROTWORD  = 5'b10110,
        OP_RCON     = 5'b10111,
        OP_SUBBYTES = 5'b11000
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SBOX,
        ST_DONE
    } state_e;

    // Indexed directly by a 4-bit round number; entries 0 and 11..15 are zero
    localparam logic [15:0][7:0] RCON_TAB = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
        8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column word holds row 0 in bits [7:0]
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = c[7:0];
        a1 = c[15:8];
        a2 = c[23:16];
        a3 = c[31:24];
        r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {r3, r2, r1, r0};
    endfunction

    // Byte k sits at row k%4, column k/4; row r rotates left by r columns
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse followed by the affine map.
module aes_sbox
    import vector_alu_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    logic [7:0] acc;
    logic [7:0] inv;

    // x^254 is the multiplicative inverse (and maps 0 to 0): build x^127 by
    // square-and-multiply, then square once more
    always_comb begin
        acc = din;
        for (int i = 0; i < 6; i++) begin
            acc = gf_mul(gf_mul(acc, acc), din);
        end
        inv  = gf_mul(acc, acc);
        dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/vector_alu_pipe.sv
// Handshaked vector ALU: per-lane integer ops plus AES round primitives,
// with SubBytes iterated over SBOX_PER_CYC lookups per cycle.
module vector_alu_pipe
    import vector_alu_pkg::*;
#(
    parameter int LANES        = 16,
    parameter int LANE_W       = 8,
    parameter int SBOX_PER_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4:0]              op,
    input  logic [LANES*LANE_W-1:0] src_a,
    input  logic [LANES*LANE_W-1:0] src_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] result,
    output logic                    busy
);

    localparam int W      = LANES * LANE_W;
    localparam int NBYTES = W / 8;
    localparam int NSB    = NBYTES / SBOX_PER_CYC;
    localparam int CNT_W  = (NSB > 1) ? $clog2(NSB) : 1;
    localparam bit AES_OK = (W == 128) && (LANE_W == 8);

    state_e           state;
    logic [4:0]       op_r;
    logic [W-1:0]     a_r, b_r;
    logic [CNT_W-1:0] sb_cnt;

    logic         accept;
    logic         to_sbox;
    logic [W-1:0] lane_res;
    logic [W-1:0] aes_res;
    logic [W-1:0] exec_res;

    logic [SBOX_PER_CYC-1:0][7:0] sb_in, sb_out;

    assign in_ready = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
    assign accept   = in_valid && in_ready;
    assign busy     = (state != ST_IDLE);
    // SUBBYTES under an illegal geometry falls back to EXEC and yields zero
    assign to_sbox  = AES_OK && (op == OP_SUBBYTES);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_W-1:0] la, lb, lr;
        logic [2:0]        sh;
        assign la = a_r[i*LANE_W +: LANE_W];
        assign lb = b_r[i*LANE_W +: LANE_W];
        assign sh = lb[2:0];

        // Lane-local op; non-lane opcodes contribute zero
        always_comb begin
            lr = '0;
            case (op_r)
                OP_ADD: lr = la + lb;
                OP_SUB: lr = la - lb;
                OP_AND: lr = la & lb;
                OP_OR:  lr = la | lb;
                OP_XOR: lr = la ^ lb;
                OP_SHL: lr = la << sh;
                OP_SHR: lr = la >> sh;
                default: lr = '0;
            endcase
        end

        assign lane_res[i*LANE_W +: LANE_W] = lr;
    end

    if (AES_OK) begin : g_aes
        // AES round primitives on the full 128-bit state; zero for other opcodes
        always_comb begin
            aes_res = '0;
            case (op_r)
                OP_ADDRK:   aes_res = a_r ^ b_r;
                OP_SHROWS:  aes_res = shift_rows(a_r);
                OP_MIXCOL: begin
                    for (int c = 0; c < 4; c++) begin
                        aes_res[32*c +: 32] = mix_col(a_r[32*c +: 32]);
                    end
                end
                OP_ROTWORD: aes_res[31:0] = {a_r[7:0], a_r[31:8]};
                OP_RCON:    aes_res[7:0]  = RCON_TAB[b_r[3:0]];
                default:    aes_res = '0;
            endcase
        end
    end else begin : g_no_aes
        assign aes_res = '0;
    end

    // Lane and AES paths are mutually exclusive by opcode, so OR them
    assign exec_res = lane_res | aes_res;

    // Pick this cycle's group of bytes for the S-box bank
    always_comb begin
        for (int j = 0; j < SBOX_PER_CYC; j++) begin
            sb_in[j] = a_r[8*(int'(sb_cnt)*SBOX_PER_CYC + j) +: 8];
        end
    end

    for (genvar j = 0; j < SBOX_PER_CYC; j++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (sb_in[j]),
            .dout (sb_out[j])
        );
    end

    // Control FSM with operand capture and registered result/out_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            sb_cnt    <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                op_r <= op;
                a_r  <= src_a;
                b_r  <= src_b;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) state <= to_sbox ? ST_SBOX : ST_EXEC;
                end
                ST_EXEC: begin
                    result    <= exec_res;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_SBOX: begin
                    for (int j = 0; j < SBOX_PER_CYC; j++) begin
                        result[8*(int'(sb_cnt)*SBOX_PER_CYC + j) +: 8] <= sb_out[j];
                    end
                    if (sb_cnt == CNT_W'(NSB - 1)) begin
                        sb_cnt    <= '0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        sb_cnt <= sb_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) state <= to_sbox ? ST_SBOX : ST_EXEC;
                        else        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_alu_pipe.sv
// Scoreboard bench for vector_alu_pipe: stimulus pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_vector_alu_pipe;
    import vector_alu_pkg::*;

    localparam int LANES = 16;
    localparam int LANE_W = 8;
    localparam int SPC = 4;
    localparam int W = LANES * LANE_W;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   op;
    logic [W-1:0] src_a, src_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    string        name_q[$];

    localparam logic [W-1:0] KPAT = 128'h0f0e0d0c0b0a09080706050403020100;

    vector_alu_pipe #(.LANES(LANES), .LANE_W(LANE_W), .SBOX_PER_CYC(SPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted output against the scoreboard head
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected nothing", result);
            end else begin
                check(name_q.pop_front(), result, exp_q.pop_front());
            end
        end
    end

    task automatic send(input string name, input logic [4:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
        int n;
        op = o; src_a = a; src_b = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: in_ready never rose within 50 cycles", name);
        end
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = 5'b0; src_a = ~a; src_b = ~b;
    endtask

    // Issue an op and measure edges from accept until out_valid
    task automatic run(input string name, input logic [4:0] o,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input int lat);
        int n;
        send(name, o, a, b, exp);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 40);
        check({name, "_latency"}, W'(n), W'(lat));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; src_a = '0; src_b = '0;
        #2;
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_result", result, '0);
        check("rst_busy", W'(busy), '0);
        check("rst_in_ready", W'(in_ready), '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", W'(in_ready), W'(1));

        run("xor", OP_XOR, {16{8'h0f}}, {16{8'hff}}, {16{8'hf0}}, 1);
        run("add_nocarry", OP_ADD, 128'h10ff, 128'h2001, 128'h3000, 1);
        run("sub_wrap", OP_SUB, '0, {16{8'h01}}, {16{8'hff}}, 1);
        run("and", OP_AND, {16{8'hcc}}, {16{8'haa}}, {16{8'h88}}, 1);
        run("or", OP_OR, {16{8'hcc}}, {16{8'haa}}, {16{8'hee}}, 1);
        run("shl", OP_SHL, {16{8'h81}}, {16{8'hf9}}, {16{8'h02}}, 1);
        run("shr", OP_SHR, {16{8'h80}}, {16{8'h07}}, {16{8'h01}}, 1);
        run("unknown_op", 5'b01111, {16{8'h33}}, {16{8'h44}}, '0, 1);
        run("subbytes", OP_SUBBYTES, KPAT, '0, 128'h76abd7fe2b670130c56f6bf27b777c63, 4);
        run("shiftrows", OP_SHROWS, KPAT, '0, 128'h0b06010c07020d08030e09040f0a0500, 1);
        run("mixcol", OP_MIXCOL, 128'h455313db, '0, 128'hbca14d8e, 1);
        run("rotword", OP_ROTWORD, {{96{1'b1}}, 32'h44332211}, '0, 128'h11443322, 1);
        run("rcon9", OP_RCON, '0, 128'h9, 128'h1b, 1);
        run("rcon0", OP_RCON, '0, 128'h0, 128'h0, 1);
        run("rcon10", OP_RCON, '0, 128'ha, 128'h36, 1);
        run("rcon11", OP_RCON, '0, 128'hab, 128'h0, 1);
        run("addroundkey", OP_ADDRK, {16{8'h5a}}, KPAT, 128'h55545756515053525d5c5f5e59585b5a, 1);
        run("nop", OP_NOP, {16{8'h77}}, {16{8'h11}}, '0, 1);

        // Back-pressure then same-edge handoff and accept
        @(negedge clk);
        out_ready = 1'b0;
        send("bp_xor", OP_XOR, {16{8'h3c}}, {16{8'h0f}}, {16{8'h33}});
        begin
            int n;
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_result", result, {16{8'h33}});
            check("bp_hold_valid", W'(out_valid), W'(1));
            check("bp_in_ready_low", W'(in_ready), '0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        op = OP_ADD; src_a = {16{8'h01}}; src_b = {16{8'h02}}; in_valid = 1'b1;
        exp_q.push_back({16{8'h03}});
        name_q.push_back("b2b_add");
        @(negedge clk);
        check("b2b_in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0; src_a = '0; src_b = '0;
        @(negedge clk);
        check("b2b_busy", W'(busy), W'(1));
        check("b2b_valid_exec", W'(out_valid), '0);
        @(negedge clk);
        check("b2b_no_bubble", W'(out_valid), W'(1));

        // Reset in cycle 2 of SUBBYTES
        @(negedge clk);
        op = OP_SUBBYTES; src_a = KPAT; src_b = '0; in_valid = 1'b1;
        begin
            int n;
            n = 0;
            while (!in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", W'(out_valid), '0);
        check("midrst_result", result, '0);
        check("midrst_busy", W'(busy), '0);
        check("midrst_in_ready", W'(in_ready), '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_in_ready_after", W'(in_ready), W'(1));
        run("after_rst_unknown", 5'b01111, {16{8'h5a}}, {16{8'ha5}}, '0, 1);
        run("after_rst_xor", OP_XOR, {16{8'h0f}}, {16{8'hff}}, {16{8'hf0}}, 1);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", W'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
